// File: rtl/cnt161_pkg.sv
// Shared types and constants for the cnt161 period-timer sequencer.
package cnt161_pkg;

  localparam int         CNT_W      = 4;
  localparam logic [7:0] CYCLES_MAX = 8'd255;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD,
    FIN
  } state_t;

endpackage

// File: rtl/cnt161_sequencer_if.sv
// Host and counter-pin bundle for the cnt161 sequencer.
// The slave side is the sequencer; the master side is the host plus the counter it drives.
interface cnt161_sequencer_if;
  import cnt161_pkg::*;

  logic             START;
  logic             STOP;
  logic             PAUSE;
  logic             AUTO;
  logic [CNT_W-1:0] PRESET;
  logic [CNT_W-1:0] LIMIT;
  logic [CNT_W-1:0] Q;
  logic             RCO;
  logic             CLRN;
  logic             LDN;
  logic             ENP;
  logic             ENT;
  logic [CNT_W-1:0] DIN;
  logic             BUSY;
  logic             DONE;
  logic [7:0]       CYCLES;
  logic             OVF;

  modport master (
    output START, STOP, PAUSE, AUTO, PRESET, LIMIT, Q, RCO,
    input  CLRN, LDN, ENP, ENT, DIN, BUSY, DONE, CYCLES, OVF
  );

  modport slave (
    input  START, STOP, PAUSE, AUTO, PRESET, LIMIT, Q, RCO,
    output CLRN, LDN, ENP, ENT, DIN, BUSY, DONE, CYCLES, OVF
  );

endinterface

// File: rtl/cnt161_tick_gen.sv
// Count-step prescaler: runs while enabled, holds its value while frozen,
// and returns to zero otherwise. The tick marks the last cycle of each step.
module cnt161_tick_gen #(
  parameter int TICK_DIV = 25000000,
  parameter int PW       = 32
) (
  input  logic CLK,
  input  logic CLR,
  input  logic enable,
  input  logic freeze,
  output logic tick
);

  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] prescaler;

  assign tick = enable && (prescaler == LAST);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      prescaler <= '0;
    end else if (enable) begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
    end else if (!freeze) begin
      prescaler <= '0;
    end
  end

endmodule

// File: rtl/cnt161_sequencer.sv
// Period-timer sequencer for the 4-bit CLRN/LDN/ENP/ENT counter: loads PRESET,
// steps once per tick up to LIMIT, then either reloads (AUTO) or stops.
module cnt161_sequencer
  import cnt161_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int PW       = 32
) (
  input logic               CLK,
  input logic               CLR,
  cnt161_sequencer_if.slave bus
);

  state_t           state;
  logic [CNT_W-1:0] preset_l;
  logic [CNT_W-1:0] limit_l;
  logic             auto_l;
  logic             tick;
  logic             abortable;

  cnt161_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PW       (PW)
  ) u_tick_gen (
    .CLK    (CLK),
    .CLR    (CLR),
    .enable (state == RUN),
    .freeze (state == HOLD),
    .tick   (tick)
  );

  assign abortable = (state == LOAD) || (state == RUN) || (state == HOLD);

  // Pulse-type pins default inactive each cycle; the branches below override them.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      state      <= IDLE;
      preset_l   <= '0;
      limit_l    <= '0;
      auto_l     <= 1'b0;
      bus.CLRN   <= 1'b0;
      bus.LDN    <= 1'b1;
      bus.ENP    <= 1'b0;
      bus.ENT    <= 1'b0;
      bus.DIN    <= '0;
      bus.BUSY   <= 1'b0;
      bus.DONE   <= 1'b0;
      bus.CYCLES <= '0;
      bus.OVF    <= 1'b0;
    end else begin
      bus.CLRN <= 1'b1;
      bus.LDN  <= 1'b1;
      bus.ENP  <= 1'b0;
      bus.DONE <= 1'b0;
      if (bus.ENP && bus.RCO) begin
        bus.OVF <= 1'b1;
      end

      if (bus.STOP && abortable) begin
        bus.CLRN <= 1'b0;
        bus.ENT  <= 1'b0;
        bus.BUSY <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            bus.ENT  <= 1'b0;
            bus.BUSY <= 1'b0;
            if (bus.START && !bus.STOP) begin
              preset_l   <= bus.PRESET;
              limit_l    <= bus.LIMIT;
              auto_l     <= bus.AUTO;
              bus.CYCLES <= '0;
              bus.OVF    <= 1'b0;
              bus.LDN    <= 1'b0;
              bus.DIN    <= bus.PRESET;
              bus.BUSY   <= 1'b1;
              state      <= LOAD;
            end
          end
          LOAD: begin
            bus.ENT <= 1'b1;
            state   <= RUN;
          end
          RUN: begin
            if (bus.PAUSE) begin
              bus.ENT <= 1'b0;
              state   <= HOLD;
            end else if (tick) begin
              if (bus.Q != limit_l) begin
                bus.ENP <= 1'b1;
              end else begin
                bus.DONE <= 1'b1;
                if (auto_l) begin
                  bus.LDN <= 1'b0;
                  bus.DIN <= preset_l;
                  if (bus.CYCLES != CYCLES_MAX) begin
                    bus.CYCLES <= bus.CYCLES + 8'd1;
                  end
                end else begin
                  bus.ENT  <= 1'b0;
                  bus.BUSY <= 1'b0;
                  state    <= FIN;
                end
              end
            end
          end
          HOLD: begin
            if (!bus.PAUSE) begin
              bus.ENT <= 1'b1;
              state   <= RUN;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            bus.ENT  <= 1'b0;
            bus.BUSY <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
